// File: rtl/rdcla_pkg.sv
// rdcla_pkg: shared widths, adder latency and issue FSM states for the rdcla adder and its controller
package rdcla_pkg;
  localparam int RDCLA_DATA_W  = 32;
  localparam int RDCLA_LATENCY = 5;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} issue_state_t;
endpackage

// File: rtl/rdcla.sv
// rdcla: recursive-doubling carry-lookahead adder, one registered prefix level per edge
// (latency = log2(DATA_W)); the partial sum a^b stays combinational on the live operands.
module rdcla
  import rdcla_pkg::*;
#(
  parameter int DATA_W = RDCLA_DATA_W
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  localparam int LVL = $clog2(DATA_W);
  logic [DATA_W-1:0] p, g;
  logic [LVL-1:0][DATA_W-1:0] gr;
  logic [LVL-2:0][DATA_W-1:0] pr;
  assign p = a ^ b;
  // Folding cin into bit 0's generate lets the prefix tree ignore cin from here on.
  assign g = (a & b) | {{(DATA_W-1){1'b0}}, p[0] & cin};
  always_ff @(posedge clk) begin
    gr[0] <= g | (p & (g << 1));
    pr[0] <= p & (p << 1);
    for (int k = 1; k < LVL; k++) gr[k] <= gr[k-1] | (pr[k-1] & (gr[k-1] << (1 << k)));
    for (int k = 1; k < LVL - 1; k++) pr[k] <= pr[k-1] & (pr[k-1] << (1 << k));
  end
  assign sum  = p ^ {gr[LVL-1][DATA_W-2:0], cin};
  assign cout = gr[LVL-1][DATA_W-1];
endmodule

// File: rtl/rdcla_issue_ctrl.sv
// rdcla_issue_ctrl: accepts add requests, holds operands on the pipelined rdcla for LATENCY+1
// edges, then captures sum/cout and returns them with the request tag over a valid/ready channel.
module rdcla_issue_ctrl
  import rdcla_pkg::*;
#(
  parameter int DATA_W  = RDCLA_DATA_W,
  parameter int LATENCY = RDCLA_LATENCY,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_cin,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_cin,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [15:0]       ops_done
);
  issue_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [TAG_W-1:0] tag;
  logic accept, drain, handoff;
  assign req_ready = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  assign drain     = (state == WAIT) & (cnt == 4'd0);
  assign handoff   = (state == RESP) & rsp_ready;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? WAIT : drain ? RESP : handoff ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tag      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_tag  <= '0;
      ops_done <= '0;
    end else begin
      state <= state_nxt;
      // Operands move only on accept so the adder's combinational a^b never glitches mid-operation.
      if (accept) begin
        add_a   <= req_a;
        add_b   <= req_b;
        add_cin <= req_cin;
        tag     <= req_tag;
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (drain) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_tag  <= tag;
      end
      if (handoff) ops_done <= ops_done + 16'd1;
    end
  end
endmodule

// File: tb/tb_rdcla_issue_ctrl.sv
// tb_rdcla_issue_ctrl: drives the controller with a real rdcla; directed vector table, corner
// sequences, then random traffic checked against an arithmetic reference model.
module tb_rdcla_issue_ctrl;
  import rdcla_pkg::*;
  localparam int DW = 32;
  localparam int LAT = RDCLA_LATENCY;
  localparam int TW = 4;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_cin = 0, rsp_ready = 0;
  logic req_ready, add_cin, add_cout, rsp_valid, rsp_cout, busy;
  logic [DW-1:0] req_a = 0, req_b = 0, add_a, add_b, add_sum, rsp_sum;
  logic [TW-1:0] req_tag = 0, rsp_tag;
  logic [15:0] ops_done, ops = 0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] a, b;
    logic cin;
    logic [3:0] tag;
    logic [31:0] sum;
    logic cout;
  } vec_t;
  vec_t vt[9];

  always #5 clk = ~clk;

  rdcla_issue_ctrl #(.DATA_W(DW), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_tag(rsp_tag), .busy(busy), .ops_done(ops_done)
  );
  rdcla #(.DATA_W(DW)) adder (
    .clk(clk), .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_a = v.a; req_b = v.b; req_cin = v.cin; req_tag = v.tag;
  endtask

  task automatic scramble();
    req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom); req_tag = 4'($urandom);
  endtask

  task automatic wait_rsp(input vec_t v, input string nm);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      chk({nm, " hold_a"}, add_a, v.a);
      chk({nm, " hold_b"}, add_b, v.b);
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, LAT + 1);
  endtask

  task automatic take_rsp(input vec_t v, input string nm);
    chk({nm, " sum"}, rsp_sum, v.sum);
    chk({nm, " cout"}, rsp_cout, v.cout);
    chk({nm, " tag"}, rsp_tag, v.tag);
    chk({nm, " ops_before"}, ops_done, ops);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    ops++;
    chk({nm, " valid_cleared"}, rsp_valid, 0);
    chk({nm, " ops_after"}, ops_done, ops);
  endtask

  task automatic do_op(input vec_t v, input string nm);
    req_valid = 1;
    drive(v);
    #1;
    chk({nm, " req_ready"}, req_ready, 1);
    tick();
    req_valid = 0;
    scramble();
    chk({nm, " busy"}, busy, 1);
    wait_rsp(v, nm);
    take_rsp(v, nm);
  endtask

  initial begin
    int acc_cyc[4];
    int n_acc, n_rsp, cyc;
    logic pend, ev, er, take, done;
    int age;
    logic [31:0] e_a, e_b, e_sum;
    logic e_cin, e_cout;
    logic [3:0] e_tag;
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 4'h3, 32'h00000000, 1'b1};
    vt[1] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 4'h5, 32'h80000000, 1'b0};
    vt[2] = '{32'h00000000, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 1'b0};
    vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1};
    vt[4] = '{32'h12345678, 32'h87654321, 1'b0, 4'h1, 32'h99999999, 1'b0};
    vt[5] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 4'h2, 32'h00000000, 1'b1};
    vt[6] = '{32'h80000000, 32'h80000000, 1'b0, 4'h4, 32'h00000000, 1'b1};
    vt[7] = '{32'hDEADBEEF, 32'h00000001, 1'b1, 4'h6, 32'hDEADBEF1, 1'b0};
    vt[8] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 4'h9, 32'hFFFFFFFF, 1'b0};

    // reset state, with a pending request that must not be seen as accepted
    req_valid = 1;
    drive(vt[3]);
    #3;
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst add_a", add_a, 0);
    chk("rst rsp_sum", rsp_sum, 0);
    chk("rst ops_done", ops_done, 0);
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    tick();

    for (int i = 0; i < 9; i++) do_op(vt[i], $sformatf("vec%0d", i));

    // backpressure: a new request waits while the result is held
    req_valid = 1;
    drive(vt[2]);
    tick();
    drive(vt[3]);
    wait_rsp(vt[2], "bp first");
    for (int i = 0; i < 10; i++) begin
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_sum", rsp_sum, vt[2].sum);
      chk("bp rsp_tag", rsp_tag, vt[2].tag);
      chk("bp req_ready", req_ready, 0);
      chk("bp add_a", add_a, vt[2].a);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("bp release req_ready", req_ready, 1);
    tick();
    rsp_ready = 0;
    req_valid = 0;
    ops++;
    chk("bp ops_done", ops_done, ops);
    chk("bp busy", busy, 1);
    chk("bp new add_a", add_a, vt[3].a);
    wait_rsp(vt[3], "bp second");
    take_rsp(vt[3], "bp second");

    // back-to-back with rsp_ready held high
    n_acc = 0; n_rsp = 0; cyc = 0;
    rsp_ready = 1;
    while (n_rsp < 4 && cyc < 80) begin
      req_valid = n_acc < 4;
      if (n_acc < 4) drive(vt[4 + n_acc]);
      #1;
      if (rsp_valid) begin
        chk("b2b sum", rsp_sum, vt[4 + n_rsp].sum);
        chk("b2b tag", rsp_tag, vt[4 + n_rsp].tag);
        n_rsp++;
        ops++;
      end
      if (req_valid && req_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 0;
    req_valid = 0;
    chk("b2b responses", n_rsp, 4);
    for (int i = 1; i < 4; i++) chk("b2b spacing", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
    chk("b2b ops_done", ops_done, ops);

    // reset while cnt==2 in WAIT
    req_valid = 1;
    drive(vt[7]);
    tick();
    req_valid = 0;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    chk("mid rst add_a", add_a, 0);
    chk("mid rst add_cin", add_cin, 0);
    chk("mid rst rsp_tag", rsp_tag, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ops_done", ops_done, 0);
    chk("mid rst req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1;
    ops = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("post rst rsp_valid", rsp_valid, 0);
      chk("post rst req_ready", req_ready, 1);
      tick();
    end

    // ops_done wrap
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    ops = 16'hFFFF;
    chk("wrap preload", ops_done, 16'hFFFF);
    do_op(vt[1], "wrap");
    chk("wrap zero", ops_done, 16'h0000);

    // random traffic against the reference model
    pend = 0; age = 0;
    e_a = 0; e_b = 0; e_cin = 0; e_sum = 0; e_cout = 0; e_tag = 0;
    for (int i = 0; i < 1500; i++) begin
      ev = pend && age >= LAT + 1;
      chk("rnd rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rnd sum", rsp_sum, e_sum);
        chk("rnd cout", rsp_cout, e_cout);
        chk("rnd tag", rsp_tag, e_tag);
      end
      if (pend) chk("rnd hold", {add_cin, add_a, add_b}, {e_cin, e_a, e_b});
      chk("rnd ops_done", ops_done, ops);
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = $urandom_range(0, 3) != 0;
      scramble();
      if ($urandom_range(0, 3) == 0) req_a = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) req_b = 32'h00000001;
      #1;
      er = !pend || (ev && rsp_ready);
      chk("rnd req_ready", req_ready, er);
      take = req_valid && er;
      done = ev && rsp_ready;
      if (take) begin
        e_a = req_a; e_b = req_b; e_cin = req_cin; e_tag = req_tag;
        {e_cout, e_sum} = 33'(req_a) + 33'(req_b) + 33'(req_cin);
      end
      tick();
      if (done) begin
        pend = 0;
        ops++;
      end
      if (pend) age++;
      if (take) begin
        pend = 1;
        age = 0;
      end
    end
    req_valid = 0;
    rsp_ready = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rdcla_issue_ctrl.md
Name: rdcla_issue_ctrl

Overview:
- Operand issue and result capture controller for the pipelined 32-bit recursive-doubling CLA (`rdcla`).
- The adder's carry network is registered, but its partial sum (a^b) is combinational on the live operands. Operands must therefore stay stable until the carry pipeline has drained.
- This block accepts add requests through a valid/ready handshake and drives `a`/`b`/`cin` into the adder. It holds them stable for LATENCY+1 clock edges, samples sum/cout, and presents the result through a valid/ready response channel.
- It sits between the requesting datapath (upstream) and the `rdcla` instance (downstream).

Parameters:
- DATA_W, 32, operand/sum width; must match the adder.
- LATENCY, 5, carry pipeline depth of the adder in clock edges; legal range 1..15.
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_cin  in  1  carry in.
- req_tag  in  TAG_W  request tag.
- add_a  out  DATA_W  held operand A to the adder.
- add_b  out  DATA_W  held operand B to the adder.
- add_cin  out  1  held carry in to the adder.
- add_sum  in  DATA_W  adder sum.
- add_cout  in  1  adder carry out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  DATA_W  captured sum.
- rsp_cout  out  1  captured carry out.
- rsp_tag  out  TAG_W  tag of the completed request.
- busy  out  1  high in WAIT or RESP.
- ops_done  out  16  count of completed responses; wraps at 0xFFFF -> 0.

Behaviour:
- Reset: one clock `clk`; reset is asynchronous and active-low, port `rst_n`.
  - While rst_n=0: state=IDLE; add_a/add_b/add_cin=0; rsp_sum/rsp_cout/rsp_tag=0; rsp_valid=0; busy=0; ops_done=0; req_ready=0.
- FSM states: IDLE, WAIT, RESP.
- req_ready (combinational):
  - req_ready = rst_n & ((state==IDLE) | (state==RESP & rsp_ready)).
  - Accept = req_valid & req_ready.
- On accept at edge E0:
  - add_a/add_b/add_cin/tag register are loaded from req_*.
  - cnt is loaded with LATENCY.
  - state becomes WAIT.
- WAIT:
  - cnt decrements by 1 per edge.
  - At the edge where state==WAIT and cnt==0 (edge E0+LATENCY+1): rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_tag<=tag, rsp_valid<=1, state->RESP.
  - req_valid is ignored in WAIT.
- RESP:
  - rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid clears and ops_done increments.
    - If a request is accepted in the same cycle, the next state is WAIT with the new operands loaded.
    - Otherwise the next state is IDLE.
- Operand hold: add_a/add_b/add_cin change only on accept. They hold their last values in IDLE and RESP, so add_* never glitch mid-operation.
- Throughput: one operation per LATENCY+2 cycles with back-to-back requests and rsp_ready=1.
- Counter: cnt width is 4 bits; ops_done wraps silently.
- Reset mid-operation:
  - Asserting rst_n low in WAIT or RESP discards the operation.
  - No rsp_valid is produced after release, and ops_done is not incremented.
- Invalid inputs: X on req_* when req_valid=0 must not propagate to add_*.

Decomposition:
- Package rdcla_pkg holds:
  - DATA_W default (32).
  - RDCLA_LATENCY constant (5).
  - typedef enum {IDLE, WAIT, RESP} issue_state_t.
- No sub-module is required. The FSM, counter and hold/capture registers form one module.
- The `rdcla` adder is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Bench connects a real `rdcla` instance.
- a=0xFFFFFFFF, b=0x00000001, cin=0, tag=0x3 -> rsp_valid rises exactly at edge E0+6. rsp_sum=0x00000000, rsp_cout=1, rsp_tag=0x3. add_a/add_b are stable for the whole of WAIT.
- a=0x7FFFFFFF, b=0, cin=1, tag=0x5 -> rsp_sum=0x80000000, rsp_cout=0, rsp_tag=0x5. ops_done goes 0->1 on the handshake.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid, with req_valid=1 -> rsp_* stay constant and req_ready=0 throughout. Raising rsp_ready accepts the next request in the same cycle.
- Back-to-back: 4 requests with req_valid and rsp_ready held high -> accepts spaced 7 cycles apart, results in order, ops_done=4.
- Reset mid-WAIT: drop rst_n when cnt=2 -> all outputs 0 immediately. After release, no rsp_valid appears for 20 cycles and req_ready=1.
- Wrap: preload by running 65536 operations (or force ops_done=0xFFFF) -> the next completion gives ops_done=0x0000.
